hyperram_burst_requester: RTL and testbench

Upstream command/data source for the HyperRAM controller. It packs an incoming byte stream (Ethernet payload) into bursts of at most MAX_BURST bytes and pushes those bytes into the controller's write FIFO. It then queues one write request per burst with an auto-advancing ring-buffer address. It also forwards external read commands into the same request queue, using credit-based flow control against the controller's request FIFO.

---
 rtl/hyperram_burst_requester.sv | 278 +++++++++++++++++++++++++++
 tb/tb_hyperram_burst_requester.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_burst_requester.sv
`timescale 1ns/1ps
// Packs a byte stream into bursts for the HyperRAM write FIFO and queues write
// and read requests with a ring-buffer address and credit-limited issue.
module hyperram_burst_requester #(
   parameter int unsigned MAX_BURST       = 1280,
   parameter logic [22:0] BASE_ADR        = 23'h000000,
   parameter logic [22:0] RING_WORDS      = 23'h100000,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk_50,
   input  logic        resetn,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        rd_cmd_valid,
   input  logic [22:0] rd_cmd_adr,
   input  logic [10:0] rd_cmd_len,
   output logic        rd_cmd_ready,
   input  logic        busy_in,
   output logic [22:0] req_adr,
   output logic [10:0] req_len,
   output logic        req_rw,
   output logic        req_strobe,
   output logic [7:0]  wr_data,
   output logic        wr_req,
   output logic [2:0]  outstanding,
   output logic [15:0] wrap_cnt
);

   localparam int unsigned AW  = 23;
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned LW  = 11;
   localparam int unsigned OW  = 3;
   localparam int unsigned WW  = 16;
   localparam int unsigned DW  = 8;

   localparam logic [AW1-1:0] HALF_BURST = AW1'(MAX_BURST / 2);
   localparam logic [AW1-1:0] RING_END   = AW1'(BASE_ADR) + AW1'(RING_WORDS);
   localparam logic [LW-1:0]  BURST_LEN  = LW'(MAX_BURST);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_PAD,
      ST_ISSUE,
      ST_GAP1,
      ST_GAP2
   } state_e;

   state_e state_q, state_d;

   logic [LW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] burst_adr_q, burst_adr_d;
   logic [AW-1:0] rd_adr_q, rd_adr_d;
   logic [LW-1:0] rd_len_q, rd_len_d;
   logic          is_rd_q, is_rd_d;
   logic          cont_q, cont_d;
   logic          busy_q;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [WW-1:0] wrap_cnt_q, wrap_cnt_d;
   logic [AW-1:0] req_adr_q, req_adr_d;
   logic [LW-1:0] req_len_q, req_len_d;
   logic          req_rw_q, req_rw_d;
   logic          req_strobe_q, req_strobe_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          wr_req_q, wr_req_d;
   logic          rd_cmd_ready_q, rd_cmd_ready_d;
   logic          s_ready_q, s_ready_d;

   logic          accept_c;
   logic          credit_free_c;
   logic          wrap_hit_c;
   logic          busy_fall_c;
   logic [LW-1:0] count_inc_c;
   logic          start_burst_c;
   logic          issue_c;
   logic          retire_c;

   assign accept_c      = s_valid & s_ready_q;
   assign credit_free_c = 32'(outstanding_q) < MAX_OUTSTANDING;
   assign wrap_hit_c    = ({1'b0, wr_ptr_q} + HALF_BURST) > RING_END;
   assign busy_fall_c   = busy_q & ~busy_in;
   assign count_inc_c   = count_q + LW'(1);

   // State register
   always_ff @(posedge clk_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = s_last ? ST_PAD : ST_FILL;
            end else if (rd_cmd_valid && credit_free_c) begin
               state_d = ST_ISSUE;
            end
         end
         ST_FILL: begin
            if (accept_c) begin
               if (s_last) begin
                  state_d = count_inc_c[0] ? ST_PAD : ST_ISSUE;
               end else if (count_inc_c == BURST_LEN) begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_PAD:   state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_GAP1;
         ST_GAP1:  state_d = ST_GAP2;
         ST_GAP2:  state_d = cont_q ? ST_FILL : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      count_d        = count_q;
      wr_ptr_d       = wr_ptr_q;
      burst_adr_d    = burst_adr_q;
      rd_adr_d       = rd_adr_q;
      rd_len_d       = rd_len_q;
      is_rd_d        = is_rd_q;
      cont_d         = cont_q;
      wrap_cnt_d     = wrap_cnt_q;
      req_adr_d      = req_adr_q;
      req_len_d      = req_len_q;
      req_rw_d       = req_rw_q;
      req_strobe_d   = 1'b0;
      wr_data_d      = wr_data_q;
      wr_req_d       = 1'b0;
      rd_cmd_ready_d = 1'b0;
      start_burst_c  = 1'b0;
      issue_c        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               count_d       = LW'(1);
               wr_data_d     = s_data;
               wr_req_d      = 1'b1;
               is_rd_d       = 1'b0;
               cont_d        = ~s_last;
               start_burst_c = 1'b1;
            end else if (rd_cmd_valid && credit_free_c) begin
               rd_cmd_ready_d = 1'b1;
               rd_adr_d       = rd_cmd_adr;
               rd_len_d       = rd_cmd_len;
               is_rd_d        = 1'b1;
               cont_d         = 1'b0;
            end
         end
         ST_FILL: begin
            if (accept_c) begin
               count_d   = count_inc_c;
               wr_data_d = s_data;
               wr_req_d  = 1'b1;
               cont_d    = ~s_last;
            end
         end
         ST_PAD: begin
            wr_data_d = '0;
            wr_req_d  = 1'b1;
            count_d   = count_inc_c;
         end
         ST_ISSUE: begin
            issue_c      = 1'b1;
            req_strobe_d = 1'b1;
            if (is_rd_q) begin
               req_adr_d = rd_adr_q;
               req_len_d = rd_len_q;
               req_rw_d  = 1'b1;
            end else begin
               req_adr_d = burst_adr_q;
               req_len_d = count_q;
               req_rw_d  = 1'b0;
               wr_ptr_d  = wr_ptr_q + AW'(count_q >> 1);
            end
         end
         ST_GAP2: begin
            if (cont_q) begin
               count_d       = '0;
               start_burst_c = 1'b1;
            end
         end
         default: ;
      endcase

      // A burst that would run past the ring end restarts at the ring base
      if (start_burst_c) begin
         if (wrap_hit_c) begin
            wr_ptr_d    = BASE_ADR;
            burst_adr_d = BASE_ADR;
            if (wrap_cnt_q != '1) begin
               wrap_cnt_d = wrap_cnt_q + WW'(1);
            end
         end else begin
            burst_adr_d = wr_ptr_q;
         end
      end
   end

   // Credit accounting; a completion with nothing outstanding is dropped
   assign retire_c = busy_fall_c && (outstanding_q != '0);

   always_comb begin
      outstanding_d = outstanding_q;
      if (issue_c && !retire_c) begin
         outstanding_d = outstanding_q + OW'(1);
      end else if (!issue_c && retire_c) begin
         outstanding_d = outstanding_q - OW'(1);
      end
      s_ready_d = ((state_d == ST_IDLE) || (state_d == ST_FILL)) &&
                  (32'(outstanding_d) < MAX_OUTSTANDING);
   end

   always_ff @(posedge clk_50 or negedge resetn) begin
      if (!resetn) begin
         count_q        <= '0;
         wr_ptr_q       <= BASE_ADR;
         burst_adr_q    <= '0;
         rd_adr_q       <= '0;
         rd_len_q       <= '0;
         is_rd_q        <= 1'b0;
         cont_q         <= 1'b0;
         busy_q         <= 1'b0;
         outstanding_q  <= '0;
         wrap_cnt_q     <= '0;
         req_adr_q      <= '0;
         req_len_q      <= '0;
         req_rw_q       <= 1'b0;
         req_strobe_q   <= 1'b0;
         wr_data_q      <= '0;
         wr_req_q       <= 1'b0;
         rd_cmd_ready_q <= 1'b0;
         s_ready_q      <= 1'b0;
      end else begin
         count_q        <= count_d;
         wr_ptr_q       <= wr_ptr_d;
         burst_adr_q    <= burst_adr_d;
         rd_adr_q       <= rd_adr_d;
         rd_len_q       <= rd_len_d;
         is_rd_q        <= is_rd_d;
         cont_q         <= cont_d;
         busy_q         <= busy_in;
         outstanding_q  <= outstanding_d;
         wrap_cnt_q     <= wrap_cnt_d;
         req_adr_q      <= req_adr_d;
         req_len_q      <= req_len_d;
         req_rw_q       <= req_rw_d;
         req_strobe_q   <= req_strobe_d;
         wr_data_q      <= wr_data_d;
         wr_req_q       <= wr_req_d;
         rd_cmd_ready_q <= rd_cmd_ready_d;
         s_ready_q      <= s_ready_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign rd_cmd_ready = rd_cmd_ready_q;
   assign req_adr      = req_adr_q;
   assign req_len      = req_len_q;
   assign req_rw       = req_rw_q;
   assign req_strobe   = req_strobe_q;
   assign wr_data      = wr_data_q;
   assign wr_req       = wr_req_q;
   assign outstanding  = outstanding_q;
   assign wrap_cnt     = wrap_cnt_q;

endmodule

// File: tb/tb_hyperram_burst_requester.sv
`timescale 1ns/1ps
// Directed bench for hyperram_burst_requester: burst packing, padding, ring
// wrap, credit stall, read/write priority and mid-burst reset.
module tb_hyperram_burst_requester;

   logic clk_50 = 1'b0;
   always #10 clk_50 = ~clk_50;

   logic        resetn_a, resetn_b, sel;
   logic [7:0]  s_data;
   logic        s_valid, s_last, rd_cmd_valid, busy_in;
   logic [22:0] rd_cmd_adr;
   logic [10:0] rd_cmd_len;

   logic        s_ready_a, rd_cmd_ready_a, req_rw_a, req_strobe_a, wr_req_a;
   logic [22:0] req_adr_a;
   logic [10:0] req_len_a;
   logic [7:0]  wr_data_a;
   logic [2:0]  outstanding_a;
   logic [15:0] wrap_cnt_a;
   logic        s_ready_b, rd_cmd_ready_b, req_rw_b, req_strobe_b, wr_req_b;
   logic [22:0] req_adr_b;
   logic [10:0] req_len_b;
   logic [7:0]  wr_data_b;
   logic [2:0]  outstanding_b;
   logic [15:0] wrap_cnt_b;

   hyperram_burst_requester u_dut_a (
      .clk_50(clk_50), .resetn(resetn_a), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready_a), .rd_cmd_valid(rd_cmd_valid),
      .rd_cmd_adr(rd_cmd_adr), .rd_cmd_len(rd_cmd_len), .rd_cmd_ready(rd_cmd_ready_a),
      .busy_in(busy_in), .req_adr(req_adr_a), .req_len(req_len_a), .req_rw(req_rw_a),
      .req_strobe(req_strobe_a), .wr_data(wr_data_a), .wr_req(wr_req_a),
      .outstanding(outstanding_a), .wrap_cnt(wrap_cnt_a)
   );

   hyperram_burst_requester #(.RING_WORDS(23'd1024)) u_dut_b (
      .clk_50(clk_50), .resetn(resetn_b), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready_b), .rd_cmd_valid(rd_cmd_valid),
      .rd_cmd_adr(rd_cmd_adr), .rd_cmd_len(rd_cmd_len), .rd_cmd_ready(rd_cmd_ready_b),
      .busy_in(busy_in), .req_adr(req_adr_b), .req_len(req_len_b), .req_rw(req_rw_b),
      .req_strobe(req_strobe_b), .wr_data(wr_data_b), .wr_req(wr_req_b),
      .outstanding(outstanding_b), .wrap_cnt(wrap_cnt_b)
   );

   logic        s_ready_m, rd_cmd_ready_m, req_rw_m, req_strobe_m, wr_req_m;
   logic [22:0] req_adr_m;
   logic [10:0] req_len_m;
   logic [7:0]  wr_data_m;
   logic [2:0]  outstanding_m;
   logic [15:0] wrap_cnt_m;

   assign s_ready_m      = sel ? s_ready_b      : s_ready_a;
   assign rd_cmd_ready_m = sel ? rd_cmd_ready_b : rd_cmd_ready_a;
   assign req_rw_m       = sel ? req_rw_b       : req_rw_a;
   assign req_strobe_m   = sel ? req_strobe_b   : req_strobe_a;
   assign wr_req_m       = sel ? wr_req_b       : wr_req_a;
   assign req_adr_m      = sel ? req_adr_b      : req_adr_a;
   assign req_len_m      = sel ? req_len_b      : req_len_a;
   assign wr_data_m      = sel ? wr_data_b      : wr_data_a;
   assign outstanding_m  = sel ? outstanding_b  : outstanding_a;
   assign wrap_cnt_m     = sel ? wrap_cnt_b     : wrap_cnt_a;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Captures FIFO writes, read acknowledges and request strobes
   int          wr_cnt;
   int          rdy_cnt;
   logic [7:0]  last_wr;
   logic [22:0] adr_q[$];
   logic [10:0] len_q[$];
   logic        rw_q[$];

   always @(negedge clk_50) begin
      if (wr_req_m) begin
         wr_cnt++;
         last_wr = wr_data_m;
      end
      if (rd_cmd_ready_m) rdy_cnt++;
      if (req_strobe_m) begin
         adr_q.push_back(req_adr_m);
         len_q.push_back(req_len_m);
         rw_q.push_back(req_rw_m);
         check("s_ready_at_strobe", 32'(s_ready_m), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic clear_mon();
      wr_cnt  = 0;
      rdy_cnt = 0;
      adr_q.delete();
      len_q.delete();
      rw_q.delete();
   endtask

   task automatic reset_sel();
      s_valid = 1'b0; s_last = 1'b0; rd_cmd_valid = 1'b0; busy_in = 1'b0;
      resetn_a = 1'b0; resetn_b = 1'b0;
      repeat (2) tick();
      if (sel) resetn_b = 1'b1; else resetn_a = 1'b1;
      tick();
      clear_mon();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int g = 0;
      s_data = d; s_last = last; s_valid = 1'b1;
      while (!s_ready_m && g < 2000) begin
         tick();
         g++;
      end
      if (!s_ready_m) check("s_ready_timeout", 32'(s_ready_m), 32'd1);
      tick();
   endtask

   task automatic send_frame(input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) send_byte(8'(seed + 8'(i)), (i == n - 1));
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_strobes(input int n, input string tag);
      int g = 0;
      while (adr_q.size() < n && g < 5000) begin
         tick();
         g++;
      end
      repeat (2) tick();
      check(tag, 32'(adr_q.size()), 32'(n));
   endtask

   task automatic busy_pulse();
      busy_in = 1'b1;
      tick();
      busy_in = 1'b0;
      tick();
   endtask

   initial begin
      sel = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
      rd_cmd_valid = 1'b0; rd_cmd_adr = '0; rd_cmd_len = '0; busy_in = 1'b0;
      resetn_a = 1'b0; resetn_b = 1'b0;
      clear_mon();
      repeat (2) tick();

      // Reset values
      check("rst_s_ready", 32'(s_ready_m), 32'd0);
      check("rst_req_strobe", 32'(req_strobe_m), 32'd0);
      check("rst_wr_req", 32'(wr_req_m), 32'd0);
      check("rst_outstanding", 32'(outstanding_m), 32'd0);
      check("rst_wrap_cnt", 32'(wrap_cnt_m), 32'd0);
      check("rst_req_adr", 32'(req_adr_m), 32'd0);
      resetn_a = 1'b1;
      tick();
      check("post_rst_s_ready", 32'(s_ready_m), 32'd1);
      clear_mon();

      // 64-byte frame
      send_frame(64, 8'h00);
      wait_strobes(1, "f64_strobes");
      check("f64_wr_cnt", 32'(wr_cnt), 32'd64);
      check("f64_adr", 32'(adr_q[0]), 32'd0);
      check("f64_len", 32'(len_q[0]), 32'd64);
      check("f64_rw", 32'(rw_q[0]), 32'd0);
      check("f64_outstanding", 32'(outstanding_m), 32'd1);
      busy_pulse();
      check("f64_retire", 32'(outstanding_m), 32'd0);
      busy_pulse();
      check("no_underflow", 32'(outstanding_m), 32'd0);

      // 5-byte frame padded to 6, then next burst address
      clear_mon();
      send_frame(5, 8'hA1);
      wait_strobes(1, "f5_strobes");
      check("f5_wr_cnt", 32'(wr_cnt), 32'd6);
      check("f5_pad_byte", 32'(last_wr), 32'h00);
      check("f5_adr", 32'(adr_q[0]), 32'd32);
      check("f5_len", 32'(len_q[0]), 32'd6);
      send_frame(2, 8'h55);
      wait_strobes(2, "f2_strobes");
      check("f2_adr", 32'(adr_q[1]), 32'd35);
      check("f2_len", 32'(len_q[1]), 32'd2);

      // 3000-byte frame split into 1280/1280/440
      reset_sel();
      send_frame(3000, 8'h00);
      wait_strobes(3, "f3000_strobes");
      check("f3000_wr_cnt", 32'(wr_cnt), 32'd3000);
      check("f3000_adr0", 32'(adr_q[0]), 32'd0);
      check("f3000_len0", 32'(len_q[0]), 32'd1280);
      check("f3000_adr1", 32'(adr_q[1]), 32'd640);
      check("f3000_len1", 32'(len_q[1]), 32'd1280);
      check("f3000_adr2", 32'(adr_q[2]), 32'd1280);
      check("f3000_len2", 32'(len_q[2]), 32'd440);
      check("f3000_outstanding", 32'(outstanding_m), 32'd3);

      // Credit exhaustion and resume
      reset_sel();
      for (int k = 0; k < 4; k++) send_frame(2, 8'(k));
      wait_strobes(4, "credit_strobes");
      check("credit_out4", 32'(outstanding_m), 32'd4);
      check("credit_s_ready", 32'(s_ready_m), 32'd0);
      rd_cmd_adr = 23'h000777; rd_cmd_len = 11'd8; rd_cmd_valid = 1'b1;
      repeat (10) tick();
      check("credit_rd_ready", 32'(rdy_cnt), 32'd0);
      rd_cmd_valid = 1'b0;
      busy_pulse();
      check("credit_out3", 32'(outstanding_m), 32'd3);
      check("credit_resume", 32'(s_ready_m), 32'd1);

      // Write wins over simultaneous read, read follows
      reset_sel();
      rd_cmd_adr = 23'h012345; rd_cmd_len = 11'd100; rd_cmd_valid = 1'b1;
      send_frame(4, 8'h10);
      for (int g = 0; g < 100 && rd_cmd_valid; g++) begin
         if (rd_cmd_ready_m) rd_cmd_valid = 1'b0;
         else tick();
      end
      wait_strobes(2, "prio_strobes");
      check("prio_w_adr", 32'(adr_q[0]), 32'd0);
      check("prio_w_len", 32'(len_q[0]), 32'd4);
      check("prio_w_rw", 32'(rw_q[0]), 32'd0);
      check("prio_r_adr", 32'(adr_q[1]), 32'h012345);
      check("prio_r_len", 32'(len_q[1]), 32'd100);
      check("prio_r_rw", 32'(rw_q[1]), 32'd1);
      check("prio_rd_ready", 32'(rdy_cnt), 32'd1);

      // Reset in the middle of a burst
      clear_mon();
      for (int k = 0; k < 5; k++) send_byte(8'(k), 1'b0);
      resetn_a = 1'b0;
      #1;
      check("midrst_wr_req", 32'(wr_req_m), 32'd0);
      check("midrst_req_adr", 32'(req_adr_m), 32'd0);
      check("midrst_req_len", 32'(req_len_m), 32'd0);
      check("midrst_req_rw", 32'(req_rw_m), 32'd0);
      check("midrst_outstanding", 32'(outstanding_m), 32'd0);
      check("midrst_s_ready", 32'(s_ready_m), 32'd0);
      s_valid = 1'b0;
      repeat (2) tick();
      resetn_a = 1'b1;
      repeat (20) tick();
      check("midrst_no_strobe", 32'(adr_q.size()), 32'd0);

      // Ring wrap with a 1024-word ring
      sel = 1'b1;
      reset_sel();
      send_frame(1280, 8'h00);
      wait_strobes(1, "wrap_strobes1");
      check("wrap_adr0", 32'(adr_q[0]), 32'd0);
      check("wrap_cnt0", 32'(wrap_cnt_m), 32'd0);
      send_frame(1280, 8'h00);
      wait_strobes(2, "wrap_strobes2");
      check("wrap_adr1", 32'(adr_q[1]), 32'd0);
      check("wrap_len1", 32'(len_q[1]), 32'd1280);
      check("wrap_cnt1", 32'(wrap_cnt_m), 32'd1);
      send_frame(1280, 8'h00);
      wait_strobes(3, "wrap_strobes3");
      check("wrap_adr2", 32'(adr_q[2]), 32'd0);
      check("wrap_cnt2", 32'(wrap_cnt_m), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
